div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Front/back-end sequencer for the iterative unsigned 64-bit divider core in the RV execute path.
- Accepts RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU and the W variants) through a valid/ready interface.
- Resolves divide-by-zero and signed-overflow locally. Otherwise sends unsigned magnitudes to the core, waits for its done pulse, then applies sign correction and W-result sign extension.
- Returns the result on a valid/ready interface.

Parameters:
- XLEN, 64, datapath width. W ops use the low XLEN/2 bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- in_word  input  1  1 = W variant (32-bit operation).
- in_a  input  XLEN  dividend.
- in_b  input  XLEN  divisor.
- flush  input  1  pipeline kill; abandons any in-flight op.
- core_start  output  1  one-cycle start pulse to the divider core.
- core_dividend  output  XLEN  unsigned dividend magnitude; held stable from start until done.
- core_divisor  output  XLEN  unsigned divisor magnitude; held stable from start until done.
- core_done  input  1  single-cycle pulse; core_quot and core_rem are valid in that cycle.
- core_quot  input  XLEN  unsigned quotient from the core.
- core_rem  input  XLEN  unsigned remainder from the core.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  XLEN  final quotient or remainder.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, core_start=0, out_result=0, core_dividend=0, core_divisor=0. Reset is honoured in any state, including while the core is busy; the core is reset by the same rst_n.
- States:
  - IDLE → ISSUE when a request is accepted and needs the core.
  - IDLE → RESP when a request is accepted and is a special case.
  - ISSUE → WAIT after exactly one cycle.
  - WAIT → RESP on core_done.
  - RESP → IDLE on out_valid && out_ready.
  - WAIT → DRAIN on flush.
  - DRAIN → IDLE on core_done.
- in_ready=1 only in IDLE. A request is accepted when in_valid && in_ready. There is no same-cycle turnaround: after the output handshake, in_ready rises the following cycle.
- Operand prep, registered at accept:
  - W ops: a and b are the low 32 bits, sign-extended for DIV/REM and zero-extended for DIVU/REMU.
  - Signed ops (DIV, REM): magnitudes are the two's-complement absolute values. neg_q = sign(a) XOR sign(b); neg_r = sign(a).
  - Unsigned ops: the operands pass through unchanged.
  - All sign tests use the effective width: 32 for W ops, XLEN otherwise.
- Special cases, resolved without the core (core_start stays 0, out_valid rises the cycle after accept):
  - b==0: quotient = all ones; remainder = a (effective width).
  - Signed op with a == most-negative and b == -1 (effective width): quotient = a; remainder = 0.
- Normal path timing, with accept at cycle T:
  - core_start=1 at T+1.
  - Stays in WAIT for the core's N cycles, with core_done at T+1+N.
  - Captures core_quot / core_rem when core_done is sampled.
  - out_valid=1 at T+2+N.
- Sign fix: quotient = neg_q ? -core_quot : core_quot; remainder = neg_r ? -core_rem : core_rem. Arithmetic is two's complement and wraps modulo 2^XLEN.
- Result select: DIV/DIVU → quotient; REM/REMU → remainder.
- W ops: out_result = sign-extension of the low 32 bits of the selected result. This applies to DIVUW and REMUW as well.
- RESP: out_result and out_valid are held stable until out_ready. out_valid drops the cycle after the handshake.
- flush:
  - In IDLE: ignored.
  - In ISSUE: the start pulse is still issued, then the block goes to DRAIN.
  - In WAIT: goes to DRAIN. If core_done arrives in the same cycle as flush, the result is discarded and the block goes directly to IDLE.
  - In RESP: drops out_valid next cycle and goes to IDLE.
  - In DRAIN: in_ready=0 and out_valid=0; the next core_done is consumed and discarded.
- core_done received in IDLE or RESP is ignored. No additional start is ever issued while the core is busy.

Test Plan:
- DIVU a=100, b=7, core latency 64 → core_start at T+1 with dividend 100 and divisor 7; out_result=14 at T+66.
- DIV a=-100, b=7 → core sees magnitudes 100 and 7; out_result=-14. REM with the same operands → -2. REM a=100, b=-7 → 2.
- DIV b=0 → out_result=0xFFFF_FFFF_FFFF_FFFF at T+1 with no core_start. REMU a=5, b=0 → 5.
- DIV a=0x8000_0000_0000_0000, b=-1 → quotient 0x8000_0000_0000_0000; REM → 0. DIVW a=0x8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- DIVUW a=0x1_FFFF_FFFE, b=1 → 0xFFFF_FFFF_FFFF_FFFE (the 32-bit result is sign-extended).
- flush in WAIT → in_ready stays 0 until the core's done pulse, no out_valid, next op correct. Hold out_ready=0 for 5 cycles → out_result stays stable. rst_n mid-WAIT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: front/back-end sequencer around an iterative unsigned divider.
// Resolves divide-by-zero and signed overflow locally. Otherwise it feeds
// magnitudes to the core, then sign-corrects and W-extends the core's result.
module div_seq_ctrl #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            flush,
   output logic            core_start,
   output logic [XLEN-1:0] core_dividend,
   output logic [XLEN-1:0] core_divisor,
   input  logic            core_done,
   input  logic [XLEN-1:0] core_quot,
   input  logic [XLEN-1:0] core_rem,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   localparam int HW = XLEN / 2;
   // Most-negative value at full width and at W width (already sign-extended)
   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
   state_t state;

   // Captured at accept, used once the core answers
   logic word_r, rem_r, neg_q_r, neg_r_r;

   logic            sgn_op, a_neg, b_neg, div_zero, ovf, acc;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_raw, spec_res;
   logic [XLEN-1:0] q_fix, r_fix, core_raw, core_res;

   assign acc = in_valid & in_ready;

   // Operand prep and special-case result, from the raw request
   always_comb begin
      sgn_op   = ~in_op[0];
      a_ext    = in_word ? {{HW{sgn_op & in_a[HW-1]}}, in_a[HW-1:0]} : in_a;
      b_ext    = in_word ? {{HW{sgn_op & in_b[HW-1]}}, in_b[HW-1:0]} : in_b;
      a_neg    = sgn_op & a_ext[XLEN-1];
      b_neg    = sgn_op & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      ovf      = sgn_op & (a_ext == (in_word ? MIN_W : MIN_D)) & (b_ext == '1);
      if (div_zero) spec_raw = in_op[1] ? a_ext : '1;
      else          spec_raw = in_op[1] ? '0    : a_ext;
      spec_res = in_word ? {{HW{spec_raw[HW-1]}}, spec_raw[HW-1:0]} : spec_raw;
   end

   // Sign correction and W extension of the core's answer
   always_comb begin
      q_fix    = neg_q_r ? -core_quot : core_quot;
      r_fix    = neg_r_r ? -core_rem  : core_rem;
      core_raw = rem_r ? r_fix : q_fix;
      core_res = word_r ? {{HW{core_raw[HW-1]}}, core_raw[HW-1:0]} : core_raw;
   end

   // Sequencer FSM with registered handshake and core-facing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         core_start    <= 1'b0;
         out_result    <= '0;
         core_dividend <= '0;
         core_divisor  <= '0;
         word_r        <= 1'b0;
         rem_r         <= 1'b0;
         neg_q_r       <= 1'b0;
         neg_r_r       <= 1'b0;
      end else begin
         core_start <= 1'b0;
         case (state)
            IDLE: if (acc) begin
               in_ready <= 1'b0;
               word_r   <= in_word;
               rem_r    <= in_op[1];
               neg_q_r  <= a_neg ^ b_neg;
               neg_r_r  <= a_neg;
               if (div_zero || ovf) begin
                  out_result <= spec_res;
                  out_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  core_dividend <= a_mag;
                  core_divisor  <= b_mag;
                  core_start    <= 1'b1;
                  state         <= ISSUE;
               end
            end
            // Start pulse is already on the wire; a flush here must still drain it
            ISSUE: state <= flush ? DRAIN : WAIT;
            WAIT: begin
               if (core_done) begin
                  if (flush) begin
                     in_ready <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     out_result <= core_res;
                     out_valid  <= 1'b1;
                     state      <= RESP;
                  end
               end else if (flush) begin
                  state <= DRAIN;
               end
            end
            RESP: if (flush || out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            DRAIN: if (core_done) begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized and directed checks of div_seq_ctrl against
// an arithmetic reference model, with a behavioural divider core.
module tb_div_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_word, flush;
   logic [1:0]  in_op;
   logic [63:0] in_a, in_b;
   logic        core_start, core_done;
   logic [63:0] core_dividend, core_divisor, core_quot, core_rem;
   logic        out_valid, out_ready;
   logic [63:0] out_result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_seq_ctrl #(.XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b), .flush(flush),
      .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
      .core_done(core_done), .core_quot(core_quot), .core_rem(core_rem),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
   );

   // Behavioural divider core: fixed latency per op, one-cycle done pulse
   int          core_lat = 4;
   int          cnt = 0;
   bit          busy = 1'b0;
   int          bad_starts = 0;
   int          zero_div = 0;
   logic [63:0] dvd, dvs;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0; cnt <= 0; core_done <= 1'b0; core_quot <= '0; core_rem <= '0;
      end else begin
         core_done <= 1'b0;
         if (core_done) busy <= 1'b0;
         if (core_start) begin
            if (busy) bad_starts <= bad_starts + 1;
            if (core_divisor == 0) zero_div <= zero_div + 1;
            busy <= 1'b1;
            dvd  <= core_dividend;
            dvs  <= core_divisor;
            cnt  <= core_lat - 1;
            if (core_lat == 1) begin
               core_done <= 1'b1;
               core_quot <= (core_divisor == 0) ? '1 : core_dividend / core_divisor;
               core_rem  <= (core_divisor == 0) ? core_dividend : core_dividend % core_divisor;
            end
         end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
               core_done <= 1'b1;
               core_quot <= (dvs == 0) ? '1 : dvd / dvs;
               core_rem  <= (dvs == 0) ? dvd : dvd % dvs;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RISC-V M semantics computed directly with signed/unsigned arithmetic
   function automatic void ref_model(input logic [1:0] op, input bit w,
                                     input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] res, output bit spec,
                                     output logic [63:0] dmag, output logic [63:0] vmag);
      longint          sa, sb, sq, sr, smin;
      longint unsigned ua, ub, uq, ur;
      int              ia, ib;
      int unsigned     wa, wb;
      logic [63:0]     sel;
      if (!op[0]) begin
         ia = a[31:0]; ib = b[31:0];
         sa = w ? longint'(ia) : longint'(a);
         sb = w ? longint'(ib) : longint'(b);
         smin = w ? -64'sd2147483648 : longint'(64'h8000_0000_0000_0000);
         spec = (sb == 0) || (sa == smin && sb == -1);
         if (sb == 0)                    begin sq = -1; sr = sa; end
         else if (sa == smin && sb == -1) begin sq = sa; sr = 0; end
         else                            begin sq = sa / sb; sr = sa % sb; end
         sel  = op[1] ? sr : sq;
         dmag = (sa < 0) ? -sa : sa;
         vmag = (sb < 0) ? -sb : sb;
      end else begin
         wa = a[31:0]; wb = b[31:0];
         ua = w ? longint'(wa) : a;
         ub = w ? longint'(wb) : b;
         spec = (ub == 0);
         if (ub == 0) begin uq = '1; ur = ua; end
         else         begin uq = ua / ub; ur = ua % ub; end
         sel  = op[1] ? ur : uq;
         dmag = ua;
         vmag = ub;
      end
      res = w ? {{32{sel[31]}}, sel[31:0]} : sel;
   endfunction

   // Present one request and wait for the accept edge; leaves us at the next negedge
   task automatic issue(input logic [1:0] op, input bit w, input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Full transaction: latency, core operands, result, hold under stall, handshake
   task automatic run_op(input logic [1:0] op, input bit w, input logic [63:0] a,
                         input logic [63:0] b, input int lat, input int stall);
      logic [63:0] er, dm, vm;
      bit sp;
      int n;
      ref_model(op, w, a, b, er, sp, dm, vm);
      core_lat = lat;
      @(negedge clk);
      issue(op, w, a, b);
      n = 1;
      chk("core_start", core_start, !sp);
      if (!sp) begin
         chk("core_dividend", core_dividend, dm);
         chk("core_divisor", core_divisor, vm);
      end
      while (!out_valid && n < lat + 20) begin @(negedge clk); n++; end
      chk("latency", n, sp ? 1 : lat + 2);
      chk("result", out_result, er);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_result", out_result, er);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", out_valid, 0);
      chk("ready_back", in_ready, 1);
   endtask

   // After a flush, nothing may be accepted or returned until the core's done
   task automatic drain_check();
      int n = 0;
      while (!core_done && n < 100) begin
         chk("drain_in_ready", in_ready, 0);
         chk("drain_out_valid", out_valid, 0);
         @(negedge clk); n++;
      end
      if (!core_done) chk("drain_timeout", 0, 1);
      @(negedge clk);
      chk("drain_release", in_ready, 1);
      chk("drain_no_out", out_valid, 0);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0: return {$urandom, $urandom};
         1: return 64'($urandom_range(0, 1000));
         2: return 64'd0;
         3: return '1;
         4: return 64'h8000_0000_0000_0000;
         default: return -64'($urandom_range(1, 1000));
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
      in_a = '0; in_b = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_dividend", core_dividend, 0);
      chk("rst_divisor", core_divisor, 0);
      rst_n = 1'b1;

      // Directed cases from the plan
      run_op(2'd1, 0, 64'd100, 64'd7, 64, 0);
      run_op(2'd0, 0, -64'd100, 64'd7, 5, 0);
      run_op(2'd2, 0, -64'd100, 64'd7, 5, 0);
      run_op(2'd2, 0, 64'd100, -64'd7, 3, 0);
      run_op(2'd0, 0, 64'd42, 64'd0, 3, 0);
      run_op(2'd3, 0, 64'd5, 64'd0, 3, 0);
      run_op(2'd0, 0, 64'h8000_0000_0000_0000, '1, 3, 0);
      run_op(2'd2, 0, 64'h8000_0000_0000_0000, '1, 3, 0);
      run_op(2'd0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 3, 0);
      run_op(2'd1, 1, 64'h1_FFFF_FFFE, 64'd1, 2, 5);
      run_op(2'd1, 0, 64'd1000, 64'd9, 1, 5);

      // flush in WAIT, then a normal op
      core_lat = 20;
      issue(2'd1, 0, 64'd1000, 64'd3);
      repeat (3) @(negedge clk);
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      drain_check();
      run_op(2'd0, 0, -64'd77, 64'd5, 4, 1);

      // flush in ISSUE: start still goes out, then drain
      core_lat = 6;
      issue(2'd3, 0, 64'd99, 64'd10);
      chk("issue_flush_start", core_start, 1);
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      drain_check();

      // flush coinciding with done goes straight to IDLE
      core_lat = 4;
      issue(2'd0, 0, 64'd50, 64'd6);
      for (int i = 0; i < 20 && !core_done; i++) @(negedge clk);
      chk("done_seen", core_done, 1);
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      chk("flush_done_ready", in_ready, 1);
      chk("flush_done_novalid", out_valid, 0);

      // flush in RESP drops the result
      issue(2'd0, 0, 64'd9, 64'd0);
      chk("resp_valid", out_valid, 1);
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      chk("resp_flush_valid", out_valid, 0);
      chk("resp_flush_ready", in_ready, 1);

      // reset in the middle of WAIT
      core_lat = 40;
      issue(2'd1, 0, 64'd12345, 64'd11);
      repeat (5) @(negedge clk);
      rst_n = 1'b0; #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_core_start", core_start, 0);
      chk("mid_rst_out_result", out_result, 0);
      chk("mid_rst_dividend", core_dividend, 0);
      chk("mid_rst_divisor", core_divisor, 0);
      @(negedge clk); rst_n = 1'b1;

      // Randomized ops
      for (int k = 0; k < 60; k++)
         run_op(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), pick(), pick(),
                $urandom_range(1, 20), $urandom_range(0, 3));

      chk("no_start_while_busy", bad_starts, 0);
      chk("no_zero_divisor", zero_div, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
